// File: rtl/piso_shift_ctrl.sv
// Sequencer for a parallel-in/serial-out register: accepts words over valid/ready,
// then issues one load strobe, WIDTH-1 shift strobes and a done pulse, with optional gap.
module piso_shift_ctrl #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] piso_d,
  output logic             piso_load,
  output logic             piso_shift,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CLK_LAST   = CLKS_PER_BIT - 1;
  localparam int unsigned CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_LAST   = WIDTH - 1;
  localparam int unsigned BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("piso_shift_ctrl: WIDTH must be >= 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("piso_shift_ctrl: CLKS_PER_BIT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic [WIDTH-1:0] piso_d_nxt;

  logic accept;
  logic bit_end;
  logic last_bit;
  logic gap_end;

  logic in_ready_nxt;
  logic busy_nxt;
  logic load_nxt;
  logic shift_nxt;
  logic done_nxt;

  assign accept   = in_valid & in_ready & ~abort;
  assign bit_end  = (clk_cnt == CW'(CLK_LAST));
  assign last_bit = (bit_cnt == BW'(BIT_LAST));
  assign gap_end  = (gap_cnt == GW'(GAP_LAST));

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      piso_d     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      piso_d     <= piso_d_nxt;
      in_ready   <= in_ready_nxt;
      busy       <= busy_nxt;
      piso_load  <= load_nxt;
      piso_shift <= shift_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    piso_d_nxt  = piso_d;
    unique case (state)
      IDLE: begin
        if (accept) begin
          piso_d_nxt = in_data;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt   = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          clk_cnt_nxt = '0;
          if (last_bit) begin
            gap_cnt_nxt = '0;
            state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      GAP: begin
        if (abort || gap_end) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state so the registered strobes line up with it
  always_comb begin
    in_ready_nxt = 1'b0;
    busy_nxt     = 1'b0;
    load_nxt     = 1'b0;
    shift_nxt    = 1'b0;
    done_nxt     = 1'b0;
    unique case (state_nxt)
      IDLE: in_ready_nxt = 1'b1;
      LOAD: begin
        busy_nxt = 1'b1;
        load_nxt = 1'b1;
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (clk_cnt_nxt == CW'(CLK_LAST)) begin
          if (bit_cnt_nxt == BW'(BIT_LAST)) begin
            done_nxt = 1'b1;
          end else begin
            shift_nxt = 1'b1;
          end
        end
      end
      GAP:     busy_nxt = 1'b1;
      default: in_ready_nxt = 1'b0;
    endcase
  end

endmodule
